// File: rtl/uart_transmitter.sv
// UART transmitter: 16x oversampled, MSB-first frame of start, data, optional parity, stop.
// Define UART_TX_PARITY_EN to insert one even-parity bit between the data and the stop bit.
module uart_transmitter #(
  parameter int DATA_BITS     = 8,
  parameter int STOP_BIT_TICK = 16
) (
  input  logic                 clk_50MHz,
  input  logic                 reset,
  input  logic                 sample_tick,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 tx
);

  localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int STOP_W = (STOP_BIT_TICK > 1) ? $clog2(STOP_BIT_TICK) : 1;
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic [STOP_W-1:0] STOP_LAST = STOP_W'(STOP_BIT_TICK - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t               r_state, w_state_next;
  logic [3:0]           r_tick_cnt, w_tick_next;
  logic [STOP_W-1:0]    r_stop_cnt, w_stop_next;
  logic [BIT_W-1:0]     r_bit_cnt, w_bit_next;
  logic [DATA_BITS-1:0] r_shift, w_shift_next;
  logic                 r_tx, w_tx_next;
  logic                 r_done, w_done_next;
  logic                 w_bit_end;
`ifdef UART_TX_PARITY_EN
  logic                 r_parity, w_parity_next;
`endif

  // A bit slot ends on the edge that counts its 16th sample tick.
  assign w_bit_end = sample_tick && (r_tick_cnt == 4'd15);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_state_next = r_state;
    w_tick_next  = r_tick_cnt;
    w_stop_next  = r_stop_cnt;
    w_bit_next   = r_bit_cnt;
    w_shift_next = r_shift;
    w_done_next  = 1'b0;
`ifdef UART_TX_PARITY_EN
    w_parity_next = r_parity;
`endif

    case (r_state)
      S_IDLE: begin
        if (tx_valid) begin
          w_shift_next = tx_data;
          w_tick_next  = 4'd0;
          w_bit_next   = '0;
          w_state_next = S_START;
`ifdef UART_TX_PARITY_EN
          w_parity_next = ^tx_data;
`endif
        end
      end
      S_START: begin
        if (sample_tick) w_tick_next = r_tick_cnt + 4'd1;
        if (w_bit_end) w_state_next = S_DATA;
      end
      S_DATA: begin
        if (sample_tick) w_tick_next = r_tick_cnt + 4'd1;
        if (w_bit_end) begin
          w_shift_next = r_shift << 1;
          w_bit_next   = r_bit_cnt + BIT_W'(1);
          if (r_bit_cnt == BIT_LAST) begin
            w_stop_next  = '0;
`ifdef UART_TX_PARITY_EN
            w_state_next = S_PARITY;
`else
            w_state_next = S_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (sample_tick) w_tick_next = r_tick_cnt + 4'd1;
        if (w_bit_end) begin
          w_stop_next  = '0;
          w_state_next = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (sample_tick) begin
          if (r_stop_cnt == STOP_LAST) begin
            w_stop_next  = '0;
            w_done_next  = 1'b1;
            w_state_next = S_IDLE;
          end else begin
            w_stop_next = r_stop_cnt + STOP_W'(1);
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase

    // The line is driven from the next state so it changes on the same edge as the state.
    case (w_state_next)
      S_START:  w_tx_next = 1'b0;
      S_DATA:   w_tx_next = w_shift_next[DATA_BITS-1];
`ifdef UART_TX_PARITY_EN
      S_PARITY: w_tx_next = w_parity_next;
`endif
      default:  w_tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk_50MHz) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      r_state    <= S_IDLE;
      r_tick_cnt <= 4'd0;
      r_stop_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
      r_done     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_next;
      r_tick_cnt <= w_tick_next;
      r_stop_cnt <= w_stop_next;
      r_bit_cnt  <= w_bit_next;
      r_shift    <= w_shift_next;
      r_tx       <= w_tx_next;
      r_done     <= w_done_next;
`ifdef UART_TX_PARITY_EN
      r_parity   <= w_parity_next;
`endif
    end
  end

  assign tx_ready = (r_state == S_IDLE);
  assign tx_busy  = (r_state != S_IDLE);
  assign tx_done  = r_done;
  assign tx       = r_tx;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: instance a uses 1 stop bit, instance b uses 2 stop bits (32 ticks).
module tb_uart_transmitter;

`ifdef UART_TX_PARITY_EN
  localparam int P     = 1;
  localparam int LEN_A = 176;
  localparam int LEN_B = 192;
`else
  localparam int P     = 0;
  localparam int LEN_A = 160;
  localparam int LEN_B = 176;
`endif

  logic       clk_50MHz;
  logic       reset;
  logic       sample_tick;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tick_div;
  logic       tx_ready_a, tx_busy_a, tx_done_a, tx_a;
  logic       tx_ready_b, tx_busy_b, tx_done_b, tx_b;
  int         n_checks;
  int         n_fail;

  uart_transmitter #(.DATA_BITS(8), .STOP_BIT_TICK(16)) dut_a (
    .clk_50MHz(clk_50MHz), .reset(reset), .sample_tick(sample_tick),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready_a),
    .tx_busy(tx_busy_a), .tx_done(tx_done_a), .tx(tx_a)
  );

  uart_transmitter #(.DATA_BITS(8), .STOP_BIT_TICK(32)) dut_b (
    .clk_50MHz(clk_50MHz), .reset(reset), .sample_tick(sample_tick),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready_b),
    .tx_busy(tx_busy_b), .tx_done(tx_done_b), .tx(tx_b)
  );

  initial begin
    clk_50MHz = 1'b0;
    forever #5 clk_50MHz = ~clk_50MHz;
  end

  // Tick every cycle, or every other cycle when tick_div is set.
  initial begin
    sample_tick = 1'b1;
    forever begin
      @(posedge clk_50MHz);
      #1;
      sample_tick = tick_div ? ~sample_tick : 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Line level in cycle c after acceptance, ticking every cycle.
  function automatic logic exp_tx(input int c, input logic [7:0] d);
    if (c < 16)                return 1'b0;
    if (c < 144)               return d[7 - ((c - 16) / 16)];
    if (P == 1 && c < 160)     return ^d;
    return 1'b1;
  endfunction

  // Called right after the acceptance edge; follows one frame to its tx_done cycle.
  task automatic watch(input int sel, input logic [7:0] d, input int len, input string tag);
    int   done_cnt;
    logic o_tx, o_done, o_ready;
    done_cnt = 0;
    for (int c = 0; c <= len; c++) begin
      @(negedge clk_50MHz);
      o_tx    = (sel != 0) ? tx_b : tx_a;
      o_done  = (sel != 0) ? tx_done_b : tx_done_a;
      o_ready = (sel != 0) ? tx_ready_b : tx_ready_a;
      if (c == 0) check($sformatf("%s_ready_c0", tag), o_ready, 1'b0);
      if (c < len) begin
        if ((c % 16 == 0) || (c % 16 == 15))
          check($sformatf("%s_tx_c%0d", tag, c), o_tx, exp_tx(c, d));
        if (o_done) done_cnt++;
      end else begin
        check($sformatf("%s_done_end", tag), o_done, 1'b1);
        check($sformatf("%s_ready_end", tag), o_ready, 1'b1);
        check($sformatf("%s_tx_end", tag), o_tx, 1'b1);
      end
    end
    check($sformatf("%s_early_done", tag), done_cnt, 0);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    tx_valid = 1'b0;
    repeat (2) @(posedge clk_50MHz);
    #1;
    reset = 1'b0;
  endtask

  task automatic accept(input logic [7:0] d, input bit hold);
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk_50MHz);
    #1;
    if (!hold) tx_valid = 1'b0;
  endtask

  initial begin
    int done_cyc;
    int dn;
    n_checks = 0;
    n_fail   = 0;
    tick_div = 1'b0;
    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;

    // Reset held with random stimulus.
    for (int i = 0; i < 3; i++) begin
      tx_valid = 1'($urandom_range(0, 1));
      tx_data  = 8'($urandom);
      @(negedge clk_50MHz);
      check($sformatf("rst_tx_%0d", i), tx_a, 1'b1);
      check($sformatf("rst_ready_%0d", i), tx_ready_a, 1'b1);
      check($sformatf("rst_busy_%0d", i), tx_busy_a, 1'b0);
      check($sformatf("rst_done_%0d", i), tx_done_a, 1'b0);
    end
    tx_valid = 1'b0;
    reset    = 1'b0;
    @(negedge clk_50MHz);
    check("post_rst_tx", tx_a, 1'b1);
    check("post_rst_ready", tx_ready_a, 1'b1);
    check("post_rst_busy", tx_busy_a, 1'b0);
    check("post_rst_done", tx_done_a, 1'b0);
    @(posedge clk_50MHz);
    #1;

    // 0x41 on both instances: 0,0100_0001,(parity 0),stop.
    accept(8'h41, 1'b0);
    fork
      watch(0, 8'h41, LEN_A, "a41");
      watch(1, 8'h41, LEN_B, "b41");
    join

    // 0x43 on both instances; parity slot is 1 when enabled.
    do_reset();
    accept(8'h43, 1'b0);
    fork
      watch(0, 8'h43, LEN_A, "a43");
      watch(1, 8'h43, LEN_B, "b43");
    join

    // Back-to-back with tx_valid held; tx_data changes mid-frame.
    do_reset();
    accept(8'h42, 1'b1);
    tx_data = 8'h43;
    watch(0, 8'h42, LEN_A, "b2b42");
    @(posedge clk_50MHz);
    #1;
    tx_valid = 1'b0;
    watch(0, 8'h43, LEN_A, "b2b43");

    // Busy protection: 0x7E presented and toggled while 0x41 is in flight.
    do_reset();
    accept(8'h41, 1'b1);
    tx_data = 8'h7E;
    fork
      watch(0, 8'h41, LEN_A, "busy41");
      begin
        repeat (6) begin
          repeat (20) @(posedge clk_50MHz);
          #1;
          tx_data = ~tx_data;
        end
      end
    join
    @(posedge clk_50MHz);
    #1;
    tx_valid = 1'b0;
    watch(0, 8'h7E, LEN_A, "busy7e");

    // Reset in the middle of data bit 3 of 0x55.
    do_reset();
    accept(8'h55, 1'b0);
    repeat (89) @(negedge clk_50MHz);
    check("mid_bit3_tx", tx_a, 1'b0);
    check("mid_bit3_busy", tx_busy_a, 1'b1);
    reset = 1'b1;
    @(negedge clk_50MHz);
    check("mid_rst_tx", tx_a, 1'b1);
    check("mid_rst_ready", tx_ready_a, 1'b1);
    check("mid_rst_done", tx_done_a, 1'b0);
    reset = 1'b0;
    dn = 0;
    repeat (20) begin
      @(negedge clk_50MHz);
      if (tx_done_a) dn++;
    end
    check("mid_rst_no_done", dn, 0);
    accept(8'hA5, 1'b0);
    fork
      watch(0, 8'hA5, LEN_A, "aA5");
      watch(1, 8'hA5, LEN_B, "bA5");
    join

    // Half-rate sample_tick: frame time doubles, ticks rather than clocks are counted.
    do_reset();
    tick_div = 1'b1;
    accept(8'h41, 1'b0);
    done_cyc = -1;
    for (int c = 0; c < 400 && done_cyc < 0; c++) begin
      @(negedge clk_50MHz);
      if (c == 20) check("div_start_tx", tx_a, 1'b0);
      if (tx_done_a) done_cyc = c;
    end
    check("div_done_cycle", (done_cyc == 319) || (done_cyc == 320), 1'b1);
    tick_div = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

Serialises parallel bytes onto the UART line, clocked by the shared 16× oversampling `sample_tick` from `baud_rate_generator`. It is the transmit counterpart of `uart_receiver`: same frame format, bit order and stop-bit parameterisation. In `uart_top` it drains the RX FIFO toward the ESP32 over `tx`, using a valid/ready byte handshake.

## Interface
- `DATA_BITS`, 8: data bits per frame.
- `STOP_BIT_TICK`, 16: stop-bit length in sample ticks; 16 = 1, 24 = 1.5, 32 = 2 stop bits.
- `clk_50MHz` in 1: system clock. One clock domain; all logic on its rising edge.
- `reset` in 1: reset is synchronous and active-high.
- `sample_tick` in 1: one-cycle strobe at 16× baud.
- `tx_valid` in 1: `tx_data` holds a byte to send.
- `tx_data` in DATA_BITS: byte to transmit. Sampled only at acceptance.
- `tx_ready` out 1: transmitter can accept a byte.
- `tx_busy` out 1: a frame is in progress.
- `tx_done` out 1: one-cycle pulse at the end of the stop bit.
- `tx` out 1: serial line, idle high, registered.

## Operation
- States are IDLE, START, DATA, PARITY (only when the macro is defined) and STOP.
- Reset values: state IDLE, `tx`=1, `tx_ready`=1, `tx_busy`=0, `tx_done`=0, tick counter 0, bit counter 0.
- IDLE:
  - `tx_ready`=1, `tx`=1.
  - On `tx_valid && tx_ready`: latch `tx_data` into the shift register, clear the tick counter and go to START.
  - `sample_tick` is ignored in IDLE.
- START: `tx`=0 for 16 sample ticks, then go to DATA.
- DATA:
  - Bits go out MSB first (bit DATA_BITS-1 down to bit 0), matching `uart_receiver`.
  - Each bit is held for 16 ticks.
  - After the last bit, go to PARITY if enabled, otherwise STOP.
- PARITY: even-parity bit (XOR of the latched data) held for 16 ticks, then go to STOP.
- STOP:
  - `tx`=1 for STOP_BIT_TICK ticks.
  - Then pulse `tx_done` and return to IDLE.
- Counters:
  - 4-bit tick counter, wraps 15→0 at each bit boundary.
  - Stop phase uses a counter wide enough for STOP_BIT_TICK-1 (5 bits covers 32).
  - Bit counter is ceil(log2(DATA_BITS)) bits wide.
- `tx_busy` = state ≠ IDLE. `tx_ready` = state == IDLE.
- `tx_valid` while busy is ignored; no byte is queued. Changing `tx_data` mid-frame has no effect.
- Reset mid-frame: the frame is abandoned, `tx`=1 on the next edge, no `tx_done` pulse.

## Timing
- Acceptance edge is E0. `tx` falls on E0, because the output register updates with the START entry.
- A bit transition occurs on the clock edge where the 16th `sample_tick` of the current bit is counted.
- Frame length is (1 + DATA_BITS + P)·16 + STOP_BIT_TICK sample ticks, with P = 1 if parity is enabled, else 0. Defaults give 160 ticks without parity, 176 with.
- `tx_done` is high for the single cycle that follows the edge entering IDLE. `tx_ready` is already 1 in that cycle.
  - If `tx_valid` is held, the next byte is accepted in that same cycle.
  - Back-to-back frames therefore have zero extra idle ticks.
- With BR_LIMIT 326, one bit is 16×326 clocks ≈ 104.3 µs (9600 bps nominal).

## Configuration
- `UART_TX_PARITY_EN` defined: PARITY state compiled in; one even-parity bit is inserted between the data bits and the stop bit.
- `UART_TX_PARITY_EN` undefined: no PARITY state and no parity logic; the frame is start, data, stop.
- The peer receiver must be built with the matching setting. The default build leaves the macro undefined.

## Test plan
- Reset: assert `reset` for 3 cycles with random `tx_valid`/`tx_data` → `tx`=1, `tx_ready`=1, `tx_busy`=0, `tx_done`=0 throughout and after release.
- Single byte 0x41, `sample_tick` every cycle → `tx` sequence in 16-cycle slots is 0, 0,1,0,0,0,0,0,1, 1. `tx_done` pulses once, 160 cycles after acceptance. A looped-back `uart_receiver` reports 0x41.
- Back-to-back 0x42 then 0x43 with `tx_valid` held → second start bit begins the cycle after `tx_done`; no idle gap. Receiver reports 0x42, 0x43.
- Busy protection: accept 0x41, then present 0x7E with `tx_valid`=1 and toggle `tx_data` mid-frame → only 0x41 is sent. 0x7E is accepted only after `tx_done`.
- Reset mid-frame: start 0x55, assert `reset` during data bit 3 → `tx`=1 on the next edge, `tx_ready`=1, no `tx_done`. A subsequent 0xA5 transmits correctly.
- `UART_TX_PARITY_EN` with STOP_BIT_TICK=32:
  - 0x41 → parity slot 0; 0x43 → parity slot 1.
  - Stop high for 32 ticks; frame 192 ticks.
  - Without the macro, the same bench measures 176 ticks.
